// File: rtl/mem_arbiter.sv
// Arbitrates the single memory bus between the instruction-fetch port and the load/store port.
// One transaction in flight at a time: IDLE -> ISSUE (bus handshake) -> WAIT_ACK (completion or timeout).
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_busy,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic [1:0]        grant
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   localparam logic [1:0] G_NONE  = 2'b00;
   localparam logic [1:0] G_FETCH = 2'b01;
   localparam logic [1:0] G_DATA  = 2'b10;

   localparam int SC_W = $clog2(STARVE_MAX + 1);
   localparam int TC_W = $clog2(TIMEOUT + 1);
   localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
   localparam logic [TC_W-1:0] TMO_LAST   = TC_W'(TIMEOUT - 1);

   logic [1:0]      state;
   logic [SC_W-1:0] starve_cnt;
   logic [TC_W-1:0] tmo_cnt;

   logic if_elig;
   logic d_elig;
   logic arb_open;
   logic pick_fetch;
   logic pick_data;
   logic done;

   function automatic logic [SC_W-1:0] starve_sat_inc(input logic [SC_W-1:0] v);
      return (v == STARVE_LIM) ? v : v + SC_W'(1);
   endfunction

   // No grant in a completion cycle, so a port re-requesting back to back competes on equal terms.
   always_comb begin
      if_elig    = if_req & ~if_ack;
      d_elig     = d_req & ~d_ack;
      arb_open   = (state == S_IDLE) & ~if_ack & ~d_ack;
      pick_fetch = arb_open & if_elig & (~d_elig | (starve_cnt == STARVE_LIM));
      pick_data  = arb_open & d_elig & ~pick_fetch;
      done       = (state == S_WAIT) & (bus_ack | (tmo_cnt == TMO_LAST));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         grant      <= G_NONE;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         if_ack     <= 1'b0;
         if_err     <= 1'b0;
         if_rdata   <= '0;
         d_ack      <= 1'b0;
         d_err      <= 1'b0;
         d_rdata    <= '0;
      end else begin
         if_ack <= 1'b0;
         if_err <= 1'b0;
         d_ack  <= 1'b0;
         d_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_fetch) begin
                  bus_addr   <= if_addr;
                  bus_we     <= 1'b0;
                  bus_wdata  <= '0;
                  bus_req    <= 1'b1;
                  grant      <= G_FETCH;
                  starve_cnt <= '0;
                  state      <= S_ISSUE;
               end else if (pick_data) begin
                  bus_addr  <= d_addr;
                  bus_we    <= d_we;
                  bus_wdata <= d_wdata;
                  bus_req   <= 1'b1;
                  grant     <= G_DATA;
                  if (if_elig) starve_cnt <= starve_sat_inc(starve_cnt);
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!bus_busy) begin
                  bus_req <= 1'b0;
                  tmo_cnt <= '0;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (done) begin
                  // A real bus_ack beats a timeout landing in the same cycle.
                  state   <= S_IDLE;
                  grant   <= G_NONE;
                  tmo_cnt <= '0;
                  if (grant == G_FETCH) begin
                     if_ack   <= 1'b1;
                     if_err   <= ~bus_ack;
                     if_rdata <= bus_ack ? bus_rdata : '0;
                  end else begin
                     d_ack   <= 1'b1;
                     d_err   <= ~bus_ack;
                     d_rdata <= (bus_ack & ~bus_we) ? bus_rdata : '0;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + TC_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected bus issues and completions,
// independent monitors pop and compare them as the DUT presents them.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_ack, if_err;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_ack, d_err;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        bus_req, bus_we, bus_busy, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [1:0]  grant;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_busy(bus_busy), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .grant(grant)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic port; logic [31:0] rdata; logic err;} cmp_t;    // port: 0 fetch, 1 data
   typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} iss_t;

   cmp_t exp_cmp[$];
   iss_t exp_iss[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   lat_f, lat_d;

   int          busy_left = 0;
   int          ack_delay = 0;
   bit          drop_acks = 1'b0;
   bit          pending   = 1'b0;
   int          wcnt      = 0;
   logic [31:0] paddr;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic expect_issue(input logic we, input logic [31:0] a, input logic [31:0] wd);
      iss_t e;
      e.we = we; e.addr = a; e.wdata = wd;
      exp_iss.push_back(e);
   endtask

   task automatic expect_done(input logic port, input logic [31:0] rd, input logic err);
      cmp_t e;
      e.port = port; e.rdata = rd; e.err = err;
      exp_cmp.push_back(e);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h40) ? 32'h0051_0093 : {a[15:0], 16'hC0DE};
   endfunction

   // Bus slave model: drives a little after each rising edge.
   initial begin
      bus_busy = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
      forever begin
         @(posedge clk); #1;
         bus_ack = 1'b0;
         if (pending) begin
            if (wcnt == 0) begin
               bus_ack   = 1'b1;
               bus_rdata = mem_word(paddr);
               pending   = 1'b0;
            end else wcnt--;
         end
         if (bus_req) begin
            if (busy_left > 0) begin
               bus_busy = 1'b1;
               busy_left--;
            end else begin
               bus_busy = 1'b0;
               if (!drop_acks) begin
                  pending = 1'b1; wcnt = ack_delay; paddr = bus_addr;
               end
            end
         end else bus_busy = 1'b0;
      end
   end

   // Monitor: bus acceptances and requester completions against the scoreboard.
   initial begin
      iss_t ei;
      cmp_t ec;
      forever begin
         @(negedge clk);
         if (bus_req && !bus_busy) begin
            if (exp_iss.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_issue: got addr %0h, expected no transaction", bus_addr);
            end else begin
               ei = exp_iss.pop_front();
               check("issue", {bus_we, bus_addr, bus_we ? bus_wdata : 32'h0}, {ei.we, ei.addr, ei.wdata});
            end
         end
         if (if_ack || d_ack) begin
            if (exp_cmp.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_ack: got if_ack=%0b d_ack=%0b, expected none", if_ack, d_ack);
            end else begin
               ec = exp_cmp.pop_front();
               check("ack_port", {if_ack, d_ack}, ec.port ? 2'b01 : 2'b10);
               check("ack_rdata", ec.port ? d_rdata : if_rdata, ec.rdata);
               check("ack_err", ec.port ? d_err : if_err, ec.err);
            end
         end
         if ((if_err && !if_ack) || (d_err && !d_ack)) begin
            n_checks++;
            $display("FAIL stray_err: got if_err=%0b d_err=%0b, expected 0 without ack", if_err, d_err);
         end
      end
   end

   task automatic fetch_req(input logic [31:0] a, output int lat);
      if_addr = a; if_req = 1'b1; lat = 0;
      do begin @(negedge clk); lat++; end while (!if_ack && lat < 64);
      if (!if_ack) begin
         n_checks++;
         $display("FAIL fetch_wait: got no if_ack in %0d cycles, expected one", lat);
      end
      if_req = 1'b0;
   endtask

   task automatic data_req(input logic we, input logic [31:0] a, input logic [31:0] wd, output int lat);
      d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1; lat = 0;
      do begin @(negedge clk); lat++; end while (!d_ack && lat < 64);
      if (!d_ack) begin
         n_checks++;
         $display("FAIL data_wait: got no d_ack in %0d cycles, expected one", lat);
      end
      d_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_grant", grant, 2'b00);
      check("rst_bus", {bus_req, bus_we, bus_addr, bus_wdata}, '0);
      check("rst_acks", {if_ack, d_ack, if_err, d_err, if_rdata, d_rdata}, '0);
      rst = 1'b0;
      @(negedge clk);

      // T1 single fetch, minimum latency
      expect_issue(1'b0, 32'h40, 32'h0);
      expect_done(1'b0, 32'h0051_0093, 1'b0);
      fork
         fetch_req(32'h40, lat_f);
         begin
            @(negedge clk);
            check("t1_bus", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, 32'h40});
            check("t1_grant", grant, 2'b01);
         end
      join
      check("t1_latency", lat_f, 3);
      repeat (2) @(negedge clk);

      // T2 collision: data first, write returns zero rdata, then fetch
      expect_issue(1'b1, 32'h1000, 32'hDEAD_BEEF);
      expect_issue(1'b0, 32'h44, 32'h0);
      expect_done(1'b1, 32'h0, 1'b0);
      expect_done(1'b0, 32'h0044_C0DE, 1'b0);
      fork
         fetch_req(32'h44, lat_f);
         data_req(1'b1, 32'h1000, 32'hDEAD_BEEF, lat_d);
      join
      check("t2_data_latency", lat_d, 3);
      repeat (2) @(negedge clk);

      // T3 starvation: four data grants, then fetch forced
      for (int i = 0; i < 4; i++) begin
         expect_issue(1'b0, 32'h1100 + 32'(4 * i), 32'h0);
         expect_done(1'b1, {16'h1100 + 16'(4 * i), 16'hC0DE}, 1'b0);
      end
      expect_issue(1'b0, 32'h48, 32'h0);
      expect_done(1'b0, 32'h0048_C0DE, 1'b0);
      expect_issue(1'b0, 32'h1110, 32'h0);
      expect_done(1'b1, 32'h1110_C0DE, 1'b0);
      fork
         fetch_req(32'h48, lat_f);
         for (int j = 0; j < 5; j++) data_req(1'b0, 32'h1100 + 32'(4 * j), 32'h0, lat_d);
      join
      repeat (2) @(negedge clk);

      // T3b starvation count cleared: data wins a fresh collision
      expect_issue(1'b1, 32'h1200, 32'h1234_5678);
      expect_issue(1'b0, 32'h4C, 32'h0);
      expect_done(1'b1, 32'h0, 1'b0);
      expect_done(1'b0, 32'h004C_C0DE, 1'b0);
      fork
         fetch_req(32'h4C, lat_f);
         data_req(1'b1, 32'h1200, 32'h1234_5678, lat_d);
      join
      repeat (2) @(negedge clk);

      // T4 backpressure: three busy cycles in ISSUE
      busy_left = 3;
      expect_issue(1'b1, 32'h1300, 32'hCAFE_F00D);
      expect_done(1'b1, 32'h0, 1'b0);
      fork
         data_req(1'b1, 32'h1300, 32'hCAFE_F00D, lat_d);
         begin
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               check("t4_held", {bus_req, bus_addr, bus_wdata}, {1'b1, 32'h1300, 32'hCAFE_F00D});
            end
            @(negedge clk);
            check("t4_released", bus_req, 1'b0);
         end
      join
      check("t4_latency", lat_d, 6);
      repeat (2) @(negedge clk);

      // T5 timeout with no bus_ack
      drop_acks = 1'b1;
      expect_issue(1'b0, 32'h2000, 32'h0);
      expect_done(1'b1, 32'h0, 1'b1);
      data_req(1'b0, 32'h2000, 32'h0, lat_d);
      check("t5_latency", lat_d, 10);
      check("t5_idle", {bus_req, grant}, 3'b000);
      drop_acks = 1'b0;
      repeat (2) @(negedge clk);

      // T5b bus_ack lands on the timeout cycle: ack wins
      ack_delay = 7;
      expect_issue(1'b0, 32'h2004, 32'h0);
      expect_done(1'b1, 32'h2004_C0DE, 1'b0);
      data_req(1'b0, 32'h2004, 32'h0, lat_d);
      check("t5b_latency", lat_d, 10);
      repeat (2) @(negedge clk);

      // T6 reset during WAIT_ACK; late bus_ack must be ignored
      ack_delay = 3;
      expect_issue(1'b0, 32'h3000, 32'h0);
      d_we = 1'b0; d_addr = 32'h3000; d_req = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_in_wait", {bus_req, grant}, {1'b0, 2'b10});
      rst = 1'b1; d_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("t6_after_rst", {bus_req, grant}, 3'b000);
      for (int m = 0; m < 6; m++) begin
         @(negedge clk);
         check("t6_no_ack", {if_ack, d_ack}, 2'b00);
      end
      ack_delay = 0;
      expect_issue(1'b0, 32'h40, 32'h0);
      expect_done(1'b0, 32'h0051_0093, 1'b0);
      fetch_req(32'h40, lat_f);
      check("t6_next_latency", lat_f, 3);

      repeat (4) @(negedge clk);
      check("issue_queue_drained", exp_iss.size(), 0);
      check("ack_queue_drained", exp_cmp.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
